key_event_uart: RTL and testbench
=================================

// Module: key_event_uart
// PURPOSE
//   Consumes the per-clock key event stream from the keyboard send stage
//   (on_event strobe + key_event byte: bit7 = pressed, bits6:0 = key index).
//   Each event is buffered in a FIFO and sent to the host over a UART, LSB first.
//   Sits between the key send stage and the board TX pin. Decouples the
//   one-event-per-clock burst rate from the much slower serial line.
// PARAMETERS
//   BAUD_DIV        434  clock cycles per UART bit (50 MHz / 115200); legal >= 2
//   FIFO_AW         4    FIFO address width; depth = 2**FIFO_AW entries
// PORTS
//   clock           in   1          system clock, all logic on rising edge
//   reset           in   1          asynchronous, active-low reset (0 = reset)
//   key_event       in   8          event byte, valid only while on_event = 1
//   on_event        in   1          push strobe, sampled every rising edge
//   clear_overflow  in   1          synchronous clear of the overflow flag
//   tx              out  1          UART serial output, idle high
//   busy            out  1          1 while a frame is on the line or the FIFO is non-empty
//   fifo_level      out  FIFO_AW+1  number of entries currently stored (0..depth)
//   overflow        out  1          sticky: an event was dropped because the FIFO was full
// BEHAVIOUR
//   Reset values (async, reset = 0): tx = 1, busy = 0, fifo_level = 0,
//     overflow = 0, FSM = IDLE, FIFO pointers = 0.
//   Reset mid-frame: the frame is abandoned and tx returns high immediately.
//     All queued events are discarded. No partial frame resumes after release.
//   FIFO push
//     - key_event is written on each edge where on_event = 1.
//     - A push is accepted if the FIFO is not full, or if a pop occurs on the same edge.
//     - When full with no pop, the event is dropped and overflow is set on that edge.
//     - overflow stays 1 until clear_overflow = 1.
//     - If a drop and clear_overflow occur on the same edge, set wins.
//   FIFO pop
//     - Occurs only in IDLE when fifo_level != 0; the head is loaded into the shift register.
//     - Pop while empty is impossible.
//     - Simultaneous push and pop leaves fifo_level unchanged.
//   Pointers: FIFO_AW+1 bits wide, wrapping modulo 2**(FIFO_AW+1).
//     full  = MSBs differ and the low bits are equal.
//     empty = pointers equal.
//   FSM (tx is a registered output; each bit lasts exactly BAUD_DIV cycles,
//   timed by a down-counter reloaded at every bit boundary):
//     IDLE   tx = 1; on non-empty: pop, load shift register, go to START.
//     START  tx = 0 for one bit time, then go to DATA with bit index 0.
//     DATA   tx = shift[0]; shift right after each bit; after bit 7 go to
//            PARITY (macro defined) or STOP.
//     PARITY tx = even parity over the 8 data bits, then go to STOP.
//     STOP   tx = 1 for one bit time, then go to IDLE.
//   Back-to-back frames: IDLE lasts one clock between the stop bit and the
//     next start bit.
//   Latency: an event pushed on edge N into an empty FIFO while IDLE is popped
//     on edge N+1, and tx falls on edge N+2.
//   busy = (state != IDLE) || (fifo_level != 0).
// CONFIGURATION
//   KEY_UART_PARITY_EN
//     - Defined: 8E1 frame, 11 bits, PARITY state present, frame = 11*BAUD_DIV
//       cycles (+1 IDLE clock between frames).
//     - Undefined: 8N1 frame, 10 bits, PARITY state and logic absent,
//       frame = 10*BAUD_DIV cycles (+1 IDLE clock between frames).
// TESTING   (BAUD_DIV = 4, FIFO_AW = 2 unless noted)
//   1. Single event 0x85, 8N1:
//      -> tx low from edge N+2.
//      -> data bits 1,0,1,0,0,0,0,1, stop = 1, each bit 4 cycles (40 cycles total).
//      -> busy falls after the stop bit.
//   2. Single event 0x85, KEY_UART_PARITY_EN defined:
//      -> parity bit = 1 after data bit 7, then stop; 44 cycles total.
//   3. Six consecutive on_event pulses (E0..E5) while IDLE and empty:
//      -> E5 dropped, overflow = 1, fifo_level peaks at 4.
//      -> E0..E4 sent in order with one IDLE clock between frames.
//   4. overflow = 1, pulse clear_overflow -> overflow = 0 on the next edge.
//      Repeat with clear asserted on the same edge as a drop -> overflow stays 1.
//   5. Assert reset = 0 during data bit 3 with 2 events queued:
//      -> tx = 1 immediately, fifo_level = 0, busy = 0.
//      -> after release, tx stays high with no output.
//   6. Push while full on the same edge the FSM pops:
//      -> push accepted, fifo_level stays 4, overflow stays 0.

Source files
------------

// File: rtl/key_event_uart.sv
// key_event_uart
//   Buffers key events (on_event strobe + key_event byte) in a small FIFO
//   and serialises each one onto a UART line, LSB first.
//
//   Optional feature macro: KEY_UART_PARITY_EN
//     defined   -> 8E1 frames (start, 8 data, even parity, stop)
//     undefined -> 8N1 frames (start, 8 data, stop)
//
//   Parameters
//     BAUD_DIV  clock cycles per UART bit (>= 2)
//     FIFO_AW   FIFO address width (>= 1), depth = 2**FIFO_AW
//
//   Ports
//     clock           system clock, rising edge
//     reset           asynchronous active-low reset
//     key_event       event byte, meaningful only while on_event = 1
//     on_event        push strobe, sampled every rising edge
//     clear_overflow  synchronous clear of the sticky overflow flag
//     tx              UART serial output (registered, idle high)
//     busy            frame in progress or FIFO non-empty
//     fifo_level      number of stored entries (0..depth)
//     overflow        sticky flag: an event was dropped on a full FIFO
//     dbg_state_o     current FSM state, for observation only
//
//   Handshake: on_event is a valid-only strobe with no ready. An event
//   arriving while the FIFO is full (and no pop happens on that edge) is
//   lost and recorded in overflow; the producer is never stalled.
module key_event_uart #(
  parameter int BAUD_DIV = 434,
  parameter int FIFO_AW  = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [7:0]       key_event,
  input  logic             on_event,
  input  logic             clear_overflow,
  output logic             tx,
  output logic             busy,
  output logic [FIFO_AW:0] fifo_level,
  output logic             overflow,
  output logic [2:0]       dbg_state_o
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] CNT_RELOAD = CW'(BAUD_DIV - 1);
  localparam int DEPTH = 2 ** FIFO_AW;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef KEY_UART_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  // FIFO storage and pointers (one extra bit to tell full from empty)
  logic [7:0]       mem_q [DEPTH];
  logic [FIFO_AW:0] wr_ptr_q, rd_ptr_q;
  logic             fifo_empty, fifo_full;
  logic             pop, push, drop;
  logic             overflow_q;

  // Transmitter
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic [7:0]    head;
`ifdef KEY_UART_PARITY_EN
  logic          par_q, par_d;
`endif

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                      (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
  assign head       = mem_q[rd_ptr_q[FIFO_AW-1:0]];

  // A pop frees the head slot on the same edge, so a push into a full FIFO
  // is still accepted then; the write lands in the slot being read out.
  assign pop  = (state_q == S_IDLE) && !fifo_empty;
  assign push = on_event && (!fifo_full || pop);
  assign drop = on_event && fifo_full && !pop;

  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q[FIFO_AW-1:0]] <= key_event;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      // A drop on the same edge as a clear keeps the flag set
      if (drop)                overflow_q <= 1'b1;
      else if (clear_overflow) overflow_q <= 1'b0;
    end
  end

  // Bit timing: cnt_q counts down from BAUD_DIV-1 inside every bit; the
  // bit boundary is the edge on which it reads zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
`ifdef KEY_UART_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          state_d = S_START;
          cnt_d   = CNT_RELOAD;
          shift_d = head;
`ifdef KEY_UART_PARITY_EN
          par_d   = ^head;
`endif
        end
      end
      S_START: begin
        if (cnt_q == '0) begin
          state_d = S_DATA;
          cnt_d   = CNT_RELOAD;
          bit_d   = 3'd0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == '0) begin
          cnt_d   = CNT_RELOAD;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef KEY_UART_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
`ifdef KEY_UART_PARITY_EN
      S_PARITY: begin
        if (cnt_q == '0) begin
          state_d = S_STOP;
          cnt_d   = CNT_RELOAD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
`endif
      S_STOP: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // tx is registered from the current state, so the line lags the state
  // register by one clock: pop on edge N+1, start bit visible from N+2.
  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_q[0];
`ifdef KEY_UART_PARITY_EN
      S_PARITY: tx_d = par_q;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      tx_q    <= 1'b1;
`ifdef KEY_UART_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
`ifdef KEY_UART_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign tx          = tx_q;
  assign fifo_level  = wr_ptr_q - rd_ptr_q;
  assign busy        = (state_q != S_IDLE) || !fifo_empty;
  assign overflow    = overflow_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_key_event_uart.sv
module tb_key_event_uart;
  localparam int BD = 4;
  localparam int AW = 2;
`ifdef KEY_UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic          clock;
  logic          reset;
  logic [7:0]    key_event;
  logic          on_event;
  logic          clear_overflow;
  logic          tx;
  logic          busy;
  logic [AW:0]   fifo_level;
  logic          overflow;
  logic [2:0]    dbg_state;

  key_event_uart #(.BAUD_DIV(BD), .FIFO_AW(AW)) dut (
    .clock          (clock),
    .reset          (reset),
    .key_event      (key_event),
    .on_event       (on_event),
    .clear_overflow (clear_overflow),
    .tx             (tx),
    .busy           (busy),
    .fifo_level     (fifo_level),
    .overflow       (overflow),
    .dbg_state_o    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic recv_frame(output logic [7:0] d, output logic p, output logic s,
                            output int t0, output bit ok);
    d = 8'h00; p = 1'b0; s = 1'b0; t0 = 0; ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (tx === 1'b0) begin
        ok = 1'b1;
        t0 = cyc;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL frame_timeout: no start bit within 300 cycles (cycle %0d)", cyc);
      return;
    end
    tick(); tick();
    check("start_bit_mid", {31'd0, tx}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      repeat (BD) tick();
      d[i] = tx;
    end
`ifdef KEY_UART_PARITY_EN
    repeat (BD) tick();
    p = tx;
`endif
    repeat (BD) tick();
    s = tx;
  endtask

  // Receive n frames and compare them with the expected queue.
  task automatic recv_and_score(input int n);
    logic [7:0] d;
    logic p, s;
    int t0, prev;
    bit ok;
    logic [7:0] e;
    prev = 0;
    for (int f = 0; f < n; f++) begin
      recv_frame(d, p, s, t0, ok);
      if (!ok) return;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
      check("frame_data", {24'd0, d}, {24'd0, e});
      check("frame_stop", {31'd0, s}, 32'd1);
`ifdef KEY_UART_PARITY_EN
      check("frame_parity", {31'd0, p}, {31'd0, ^e});
`endif
      if (f > 0) check("frame_spacing", t0 - prev, 4 * NBITS + 1);
      prev = t0;
    end
  endtask

  // Single event from idle, checked cycle by cycle against hand values.
  typedef struct {
    logic [7:0] ev;
    logic       par;   // even parity bit, hand computed
  } vec_t;
  vec_t vecs[6];

  task automatic send_one_strict(input vec_t v);
    logic exp_bit;
    int b;
    key_event = v.ev;
    on_event  = 1'b1;
    tick();                       // edge N: push
    on_event  = 1'b0;
    check("lat_level_n", {29'd0, fifo_level}, 32'd1);
    check("lat_tx_n", {31'd0, tx}, 32'd1);
    tick();                       // edge N+1: pop
    check("lat_level_n1", {29'd0, fifo_level}, 32'd0);
    check("lat_tx_n1", {31'd0, tx}, 32'd1);
    check("lat_state_n1", {29'd0, dbg_state}, 32'd1);
    for (int c = 0; c < NBITS * BD; c++) begin
      tick();                     // edge N+2+c
      b = c / BD;
      if (b == 0) exp_bit = 1'b0;
      else if (b <= 8) exp_bit = v.ev[b-1];
      else if (b == NBITS - 1) exp_bit = 1'b1;
      else exp_bit = v.par;
      check("frame_bit", {31'd0, tx}, {31'd0, exp_bit});
      if (c == 0) check("busy_in_frame", {31'd0, busy}, 32'd1);
      if (c == NBITS * BD - 1) check("busy_after_stop", {31'd0, busy}, 32'd0);
    end
    tick();
    check("idle_tx", {31'd0, tx}, 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (busy === 1'b0) begin
        done = 1'b1;
        break;
      end
    end
    check("drain_done", {31'd0, done}, 32'd1);
  endtask

  // ---------------- test sequence ----------------
  logic [7:0] burst [6];
  int         burst_lvl [6];
  bit         saw_activity;

  initial begin
    vecs[0] = '{ev: 8'h85, par: 1'b1};
    vecs[1] = '{ev: 8'h00, par: 1'b0};
    vecs[2] = '{ev: 8'hFF, par: 1'b0};
    vecs[3] = '{ev: 8'h7E, par: 1'b0};
    vecs[4] = '{ev: 8'h01, par: 1'b1};
    vecs[5] = '{ev: 8'hA5, par: 1'b0};
    burst[0] = 8'h11; burst[1] = 8'h22; burst[2] = 8'h33;
    burst[3] = 8'h44; burst[4] = 8'h55; burst[5] = 8'h66;
    burst_lvl[0] = 1; burst_lvl[1] = 1; burst_lvl[2] = 2;
    burst_lvl[3] = 3; burst_lvl[4] = 4; burst_lvl[5] = 4;

    reset = 1'b0; key_event = 8'h00; on_event = 1'b0; clear_overflow = 1'b0;
    repeat (3) tick();
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_level", {29'd0, fifo_level}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_state", {29'd0, dbg_state}, 32'd0);
    reset = 1'b1;
    repeat (2) tick();

    // Single events, exact bit timing
    for (int i = 0; i < 6; i++) send_one_strict(vecs[i]);

    // Burst of six: E5 dropped, E0..E4 sent back to back
    for (int i = 0; i < 5; i++) exp_q.push_back(burst[i]);
    fork
      begin
        on_event = 1'b1;
        for (int i = 0; i < 6; i++) begin
          key_event = burst[i];
          tick();
          check("burst_level", {29'd0, fifo_level}, burst_lvl[i]);
          check("burst_overflow", {31'd0, overflow}, (i == 5) ? 32'd1 : 32'd0);
        end
        on_event = 1'b0;
      end
      recv_and_score(5);
    join
    repeat (3) tick();
    check("burst_drained", {31'd0, busy}, 32'd0);

    // Overflow sticky, clear, and clear colliding with a drop
    check("ovf_sticky", {31'd0, overflow}, 32'd1);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    check("ovf_cleared", {31'd0, overflow}, 32'd0);
    on_event = 1'b1;
    for (int i = 0; i < 6; i++) begin
      key_event = 8'hC0 + 8'(i);
      clear_overflow = (i == 5);
      tick();
    end
    on_event = 1'b0;
    clear_overflow = 1'b0;
    check("ovf_set_wins", {31'd0, overflow}, 32'd1);
    tick();
    check("ovf_set_holds", {31'd0, overflow}, 32'd1);
    wait_idle(400);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    check("ovf_cleared2", {31'd0, overflow}, 32'd0);

    // Reset during data bit 3 with two events queued
    on_event = 1'b1;
    key_event = 8'h35; tick();
    key_event = 8'h36; tick();
    key_event = 8'h37; tick();    // edge N+2
    on_event = 1'b0;
    repeat (17) tick();           // edge N+19: inside data bit 3
    check("pre_rst_tx_bit3", {31'd0, tx}, 32'd0);
    check("pre_rst_level", {29'd0, fifo_level}, 32'd2);
    reset = 1'b0;
    #1;
    check("mid_rst_tx", {31'd0, tx}, 32'd1);
    check("mid_rst_level", {29'd0, fifo_level}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    repeat (2) tick();
    reset = 1'b1;
    saw_activity = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (tx !== 1'b1 || busy !== 1'b0) saw_activity = 1'b1;
    end
    check("post_rst_quiet", {31'd0, saw_activity}, 32'd0);

    // Push into a full FIFO on the pop edge
    on_event = 1'b1;
    for (int i = 0; i < 5; i++) begin
      key_event = 8'h50 + 8'(i);
      tick();
    end
    on_event = 1'b0;
    check("full_level", {29'd0, fifo_level}, 32'd4);
    for (int i = 1; i < 6; i++) exp_q.push_back(8'h50 + 8'(i));
    begin
      bit found;
      found = 1'b0;
      for (int i = 0; i < 100; i++) begin
        tick();
        if (dbg_state === 3'd0) begin
          found = 1'b1;
          break;
        end
      end
      check("reach_idle", {31'd0, found}, 32'd1);
    end
    key_event = 8'h55;
    on_event = 1'b1;
    tick();
    on_event = 1'b0;
    check("pushpop_level", {29'd0, fifo_level}, 32'd4);
    check("pushpop_overflow", {31'd0, overflow}, 32'd0);
    check("pushpop_state", {29'd0, dbg_state}, 32'd1);
    recv_and_score(5);
    wait_idle(50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
